// File: rtl/fft8_frame_ctrl.sv
// fft8_frame_ctrl: frame sequencer for the 8-point radix-2 FFT core.
// It gathers 8 serial complex samples and presents them in parallel to the core.
// It then waits PIPE_LAT+1 cycles and captures the core outputs.
// Finally it streams the 8 bins out with a valid/ready handshake.
// Optional feature: define FFT8_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module fft8_frame_ctrl #(
  parameter int DW       = 16,
  parameter int PIPE_LAT = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            abort,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [DW-1:0]   s_real,
  input  logic [DW-1:0]   s_imag,
  output logic [8*DW-1:0] core_in_real,
  output logic [8*DW-1:0] core_in_imag,
  input  logic [8*DW-1:0] core_out_real,
  input  logic [8*DW-1:0] core_out_imag,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [DW-1:0]   m_real,
  output logic [DW-1:0]   m_imag,
  output logic [2:0]      m_index,
  output logic            m_last,
  output logic            busy
`ifdef FFT8_FRAME_CNT_EN
  ,
  output logic [15:0]     frame_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Compare value for the latency counter; PIPE_LAT is limited to 1..15.
  localparam logic [3:0] LAT = 4'(PIPE_LAT);

  state_t      state_reg;
  logic [2:0]  wr_idx_reg;
  logic [2:0]  rd_idx_reg;
  logic [3:0]  wait_cnt_reg;
  logic        m_valid_reg;
  logic        m_last_reg;
  logic        busy_reg;

  logic [DW-1:0] inbuf_real_reg  [8];
  logic [DW-1:0] inbuf_imag_reg  [8];
  logic [DW-1:0] outbuf_real_reg [8];
  logic [DW-1:0] outbuf_imag_reg [8];

  // Handshake and capture qualifiers; abort cancels any transfer in its cycle.
  logic s_fire;
  logic m_fire;
  logic capture;

  assign s_ready = (state_reg == ST_FILL) & ~rst;
  assign s_fire  = s_valid & s_ready & ~abort;
  assign m_fire  = m_valid_reg & m_ready & ~abort & ~rst;
  assign capture = (state_reg == ST_WAIT) & (wait_cnt_reg == LAT) & ~abort & ~rst;

  // Input buffer: written in sample order; untouched by abort so core_in stays put.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 8; k++) begin
        inbuf_real_reg[k] <= '0;
        inbuf_imag_reg[k] <= '0;
      end
    end else if (s_fire) begin
      inbuf_real_reg[wr_idx_reg] <= s_real;
      inbuf_imag_reg[wr_idx_reg] <= s_imag;
    end
  end

  // Output buffer: snapshot of all 16 core result words on the capture edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 8; k++) begin
        outbuf_real_reg[k] <= '0;
        outbuf_imag_reg[k] <= '0;
      end
    end else if (capture) begin
      for (int k = 0; k < 8; k++) begin
        outbuf_real_reg[k] <= core_out_real[k*DW +: DW];
        outbuf_imag_reg[k] <= core_out_imag[k*DW +: DW];
      end
    end
  end

  // Frame FSM with its indices, latency counter and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_FILL;
      wr_idx_reg   <= '0;
      rd_idx_reg   <= '0;
      wait_cnt_reg <= '0;
      m_valid_reg  <= 1'b0;
      m_last_reg   <= 1'b0;
      busy_reg     <= 1'b0;
    end else if (abort) begin
      state_reg    <= ST_FILL;
      wr_idx_reg   <= '0;
      rd_idx_reg   <= '0;
      wait_cnt_reg <= '0;
      m_valid_reg  <= 1'b0;
      m_last_reg   <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      case (state_reg)
        ST_FILL: begin
          if (s_fire) begin
            wr_idx_reg <= wr_idx_reg + 3'd1;
            if (wr_idx_reg == 3'd7) begin
              state_reg    <= ST_WAIT;
              wait_cnt_reg <= '0;
              busy_reg     <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          wait_cnt_reg <= wait_cnt_reg + 4'd1;
          if (capture) begin
            state_reg   <= ST_DRAIN;
            rd_idx_reg  <= '0;
            m_valid_reg <= 1'b1;
            m_last_reg  <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (m_fire) begin
            if (rd_idx_reg == 3'd7) begin
              state_reg   <= ST_FILL;
              wr_idx_reg  <= '0;
              rd_idx_reg  <= '0;
              m_valid_reg <= 1'b0;
              m_last_reg  <= 1'b0;
              busy_reg    <= 1'b0;
            end else begin
              rd_idx_reg <= rd_idx_reg + 3'd1;
              m_last_reg <= (rd_idx_reg == 3'd6);
            end
          end
        end
        default: begin
          state_reg   <= ST_FILL;
          m_valid_reg <= 1'b0;
          m_last_reg  <= 1'b0;
          busy_reg    <= 1'b0;
        end
      endcase
    end
  end

  // Parallel view of the input buffer feeding the core.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_core_in
      assign core_in_real[gi*DW +: DW] = inbuf_real_reg[gi];
      assign core_in_imag[gi*DW +: DW] = inbuf_imag_reg[gi];
    end
  endgenerate

  // The output bin is selected from registers only, so it holds while stalled.
  assign m_valid = m_valid_reg;
  assign m_real  = outbuf_real_reg[rd_idx_reg];
  assign m_imag  = outbuf_imag_reg[rd_idx_reg];
  assign m_index = rd_idx_reg;
  assign m_last  = m_last_reg;
  assign busy    = busy_reg;

`ifdef FFT8_FRAME_CNT_EN
  logic [15:0] frame_cnt_reg;

  // Completed-frame counter: advances when bin 7 is accepted; abort leaves it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_reg <= '0;
    end else if (m_fire && (rd_idx_reg == 3'd7)) begin
      frame_cnt_reg <= frame_cnt_reg + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_reg;
`endif

endmodule
